// File: rtl/servo_pkg.sv
// Shared servo constants and state type for the PWM generator, capture and UI blocks.
package servo_pkg;

  localparam int unsigned PERIOD_NUM  = 999999;
  localparam int unsigned MIN_NUM     = 24999;
  localparam int unsigned MAX_NUM     = 124999;
  localparam int unsigned ONE_DEG_NUM = 555;
  localparam int unsigned MAX_DEG     = 180;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} cap_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/servo_deg_div.sv
// Repeated-subtraction divider: one subtraction per cycle, quotient saturates at MAX_DEG.
module servo_deg_div
  import servo_pkg::*;
#(
  parameter int unsigned ONE_DEG_NUM = servo_pkg::ONE_DEG_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [32:0] dividend,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient
);

  localparam logic signed [32:0] Step    = 33'(ONE_DEG_NUM);
  localparam logic [7:0]         MaxIter = 8'(MAX_DEG + 1);
  localparam logic [7:0]         MaxQ    = 8'(MAX_DEG);

  logic signed [32:0] rem_q, rem_d;
  logic [7:0]         iter_q, iter_d;
  logic               busy_q, busy_d;
  logic               step_en;

  // A negative remainder never passes the compare, so d < 0 yields zero.
  assign step_en = busy_q && (rem_q >= Step) && (iter_q < MaxIter);

  always_comb begin
    rem_d  = rem_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = $signed(dividend);
      iter_d = '0;
      busy_d = 1'b1;
    end else if (step_en) begin
      rem_d  = rem_q - Step;
      iter_d = iter_q + 8'd1;
    end else if (busy_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q & ~step_en;
  assign quotient = (iter_q > MaxQ) ? MaxQ : iter_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high time and period, converts high time to 0..180 degrees.
// Optional CAPTURE_AVG_EN converts the mean of the last four latched high counts.
module servo_pwm_capture
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_NUM  = servo_pkg::PERIOD_NUM,
  parameter int unsigned MIN_NUM     = servo_pkg::MIN_NUM,
  parameter int unsigned MAX_NUM     = servo_pkg::MAX_NUM,
  parameter int unsigned ONE_DEG_NUM = servo_pkg::ONE_DEG_NUM,
  parameter int unsigned PERIOD_TOL  = 20000,
  parameter int unsigned TIMEOUT_NUM = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [31:0] high_num,
  output logic [31:0] period_num,
  output logic [7:0]  deg,
  output logic        valid,
  output logic        range_err,
  output logic        period_err,
  output logic        lost
);

  localparam logic [31:0] HighLo    = 32'(MIN_NUM);
  localparam logic [31:0] HighHi    = 32'(MAX_NUM + ONE_DEG_NUM);
  localparam logic [31:0] PerLo     = 32'(PERIOD_NUM + 1 - PERIOD_TOL);
  localparam logic [31:0] PerHi     = 32'(PERIOD_NUM + 1 + PERIOD_TOL);
  localparam logic [31:0] Timeout   = 32'(TIMEOUT_NUM);
  localparam logic [32:0] DivOffset = 33'(ONE_DEG_NUM / 2) - 33'(MIN_NUM);

  logic        sync1_q, s_q, s_prev_q, rise, fall;
  cap_state_e  state_q, state_d;
  logic [31:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [31:0] cap_high_q, cap_high_d, cap_period_q, cap_period_d;
  logic        cap_rerr_q, cap_rerr_d, cap_perr_q, cap_perr_d, drop_q, drop_d;
  logic [31:0] high_num_q, high_num_d, period_num_q, period_num_d;
  logic [7:0]  deg_q, deg_d;
  logic        valid_q, valid_d, range_err_q, range_err_d;
  logic        period_err_q, period_err_d, lost_q, lost_d;
  logic        latch, timeout, conv_ok, div_start, div_busy, div_done;
  logic [7:0]  div_quot;
  logic [31:0] conv_high;
  logic [32:0] div_dividend;

  assign rise = s_q & ~s_prev_q;
  assign fall = ~s_q & s_prev_q;

`ifdef CAPTURE_AVG_EN
  logic [31:0] hist_q [3];
  logic [31:0] hist_d [3];
  logic [1:0]  nsamp_q, nsamp_d;
  logic [33:0] avg_sum;

  assign avg_sum   = 34'(hist_q[0]) + 34'(hist_q[1]) + 34'(hist_q[2]) + 34'(hcnt_q);
  assign conv_high = 32'(avg_sum >> 2);
  assign conv_ok   = (nsamp_q == 2'd3);

  always_comb begin
    hist_d  = hist_q;
    nsamp_d = nsamp_q;
    if (timeout) begin
      nsamp_d = '0;
    end else if (latch) begin
      hist_d[2] = hist_q[1];
      hist_d[1] = hist_q[0];
      hist_d[0] = hcnt_q;
      if (nsamp_q != 2'd3) nsamp_d = nsamp_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '{default: '0};
      nsamp_q <= '0;
    end else begin
      hist_q  <= hist_d;
      nsamp_q <= nsamp_d;
    end
  end
`else
  assign conv_high = hcnt_q;
  assign conv_ok   = 1'b1;
`endif

  assign div_dividend = {1'b0, conv_high} + DivOffset;
  assign div_start    = latch & conv_ok & ~div_busy;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    pcnt_d       = pcnt_q;
    cap_high_d   = cap_high_q;
    cap_period_d = cap_period_q;
    cap_rerr_d   = cap_rerr_q;
    cap_perr_d   = cap_perr_q;
    drop_d       = drop_q;
    high_num_d   = high_num_q;
    period_num_d = period_num_q;
    deg_d        = deg_q;
    range_err_d  = range_err_q;
    period_err_d = period_err_q;
    lost_d       = lost_q;
    valid_d      = 1'b0;
    latch        = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          hcnt_d  = 32'd1;
          pcnt_d  = 32'd1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (pcnt_q >= Timeout) begin
          timeout = 1'b1;
        end else begin
          pcnt_d = sat_inc(pcnt_q);
          if (fall) state_d = StLow;
          else      hcnt_d  = sat_inc(hcnt_q);
        end
      end
      StLow: begin
        if (pcnt_q >= Timeout) begin
          timeout = 1'b1;
        end else if (rise) begin
          latch   = 1'b1;
          hcnt_d  = 32'd1;
          pcnt_d  = 32'd1;
          state_d = StHigh;
        end else begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
      default: state_d = StIdle;
    endcase

    // A sample arriving while the divider is busy is lost; flag it on the next result.
    if (latch && conv_ok) begin
      if (div_busy) begin
        drop_d = 1'b1;
      end else begin
        cap_high_d   = hcnt_q;
        cap_period_d = pcnt_q;
        cap_rerr_d   = (hcnt_q < HighLo) || (hcnt_q > HighHi);
        cap_perr_d   = (pcnt_q < PerLo) || (pcnt_q > PerHi) || drop_q;
        drop_d       = 1'b0;
      end
    end

    if (div_done) begin
      high_num_d   = cap_high_q;
      period_num_d = cap_period_q;
      deg_d        = div_quot;
      range_err_d  = cap_rerr_q;
      period_err_d = cap_perr_q;
      valid_d      = 1'b1;
      lost_d       = 1'b0;
    end

    if (timeout) begin
      state_d = StIdle;
      lost_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_prev_q     <= 1'b0;
      state_q      <= StIdle;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      cap_high_q   <= '0;
      cap_period_q <= '0;
      cap_rerr_q   <= 1'b0;
      cap_perr_q   <= 1'b0;
      drop_q       <= 1'b0;
      high_num_q   <= '0;
      period_num_q <= '0;
      deg_q        <= '0;
      valid_q      <= 1'b0;
      range_err_q  <= 1'b0;
      period_err_q <= 1'b0;
      lost_q       <= 1'b1;
    end else begin
      sync1_q      <= pwm_in;
      s_q          <= sync1_q;
      s_prev_q     <= s_q;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      cap_high_q   <= cap_high_d;
      cap_period_q <= cap_period_d;
      cap_rerr_q   <= cap_rerr_d;
      cap_perr_q   <= cap_perr_d;
      drop_q       <= drop_d;
      high_num_q   <= high_num_d;
      period_num_q <= period_num_d;
      deg_q        <= deg_d;
      valid_q      <= valid_d;
      range_err_q  <= range_err_d;
      period_err_q <= period_err_d;
      lost_q       <= lost_d;
    end
  end

  servo_deg_div #(
    .ONE_DEG_NUM(ONE_DEG_NUM)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(div_dividend),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  assign high_num   = high_num_q;
  assign period_num = period_num_q;
  assign deg        = deg_q;
  assign valid      = valid_q;
  assign range_err  = range_err_q;
  assign period_err = period_err_q;
  assign lost       = lost_q;

endmodule
